// File: rtl/fifo_rd_serializer_if.sv
// Handshake bundle between the FIFO read port, the serializer and the serial sink.
// Signal prefixes are from the serializer's point of view (i_ = into it, o_ = out of it).
interface fifo_rd_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int WCNT_W     = 16
);
  logic                  i_enable;
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  o_fifo_cs;
  logic                  o_fifo_rd_en;
  logic                  o_ser_out;
  logic                  o_ser_valid;
  logic                  i_ser_ready;
  logic                  o_frame_start;
  logic                  o_busy;
  logic [WCNT_W-1:0]     o_word_count;

  modport master (
    input  i_enable, i_fifo_empty, i_fifo_data, i_ser_ready,
    output o_fifo_cs, o_fifo_rd_en, o_ser_out, o_ser_valid,
           o_frame_start, o_busy, o_word_count
  );

  modport slave (
    output i_enable, i_fifo_empty, i_fifo_data, i_ser_ready,
    input  o_fifo_cs, o_fifo_rd_en, o_ser_out, o_ser_valid,
           o_frame_start, o_busy, o_word_count
  );
endinterface

// File: rtl/fifo_rd_serializer.sv
// Pops words from the synchronous FIFO and sends them LSB-first over a valid/ready bit link.
// Optional even-parity trailer bit is enabled by defining PARITY_EN.
module fifo_rd_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int WCNT_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  fifo_rd_serializer_if.master  bus
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    CAP   = 3'd2,
    SHIFT = 3'd3,
`ifdef PARITY_EN
    PAR   = 3'd5,
`endif
    DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [BW-1:0]         r_bitcnt;
  logic [WCNT_W-1:0]     r_wcnt;
  logic                  w_start;
  logic                  w_last;
`ifdef PARITY_EN
  logic                  r_parity;
`endif

  assign w_start = bus.i_enable & ~bus.i_fifo_empty;
  assign w_last  = (r_bitcnt == LAST_BIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_start) w_next = RD;
      RD:    w_next = CAP;
      CAP:   w_next = SHIFT;
      SHIFT: begin
        if (bus.i_ser_ready && w_last) begin
`ifdef PARITY_EN
          w_next = PAR;
`else
          w_next = DONE;
`endif
        end
      end
`ifdef PARITY_EN
      PAR:   if (bus.i_ser_ready) w_next = DONE;
`endif
      DONE:  w_next = w_start ? RD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FIFO data_out is valid one cycle after the RD pulse, hence the capture in CAP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_wcnt   <= '0;
`ifdef PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        CAP: begin
          r_shreg  <= bus.i_fifo_data;
          r_bitcnt <= '0;
`ifdef PARITY_EN
          r_parity <= ^bus.i_fifo_data;
`endif
        end
        SHIFT: begin
          if (bus.i_ser_ready) begin
            r_shreg  <= r_shreg >> 1;
            r_bitcnt <= r_bitcnt + BW'(1);
          end
        end
        DONE:    r_wcnt <= r_wcnt + WCNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.o_fifo_cs     = (r_state == RD);
  assign bus.o_fifo_rd_en  = (r_state == RD);
  assign bus.o_frame_start = (r_state == SHIFT) && (r_bitcnt == '0);
  assign bus.o_busy        = (r_state != IDLE);
  assign bus.o_word_count  = r_wcnt;
`ifdef PARITY_EN
  assign bus.o_ser_valid   = (r_state == SHIFT) || (r_state == PAR);
  assign bus.o_ser_out     = ((r_state == SHIFT) & r_shreg[0]) | ((r_state == PAR) & r_parity);
`else
  assign bus.o_ser_valid   = (r_state == SHIFT);
  assign bus.o_ser_out     = (r_state == SHIFT) & r_shreg[0];
`endif

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Scoreboard bench for fifo_rd_serializer: a queue-based FIFO model feeds the DUT and
// expected serial bits are queued per word; a negedge monitor pops and compares.
module tb_fifo_rd_serializer;
  localparam int DW = 32;
  localparam int WW = 16;
`ifdef PARITY_EN
  localparam int FRAME_BITS = DW + 1;
`else
  localparam int FRAME_BITS = DW;
`endif

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  fifo_rd_serializer_if #(.DATA_WIDTH(DW), .WCNT_W(WW)) sif ();

  fifo_rd_serializer #(.DATA_WIDTH(DW), .WCNT_W(WW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (sif)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  exp_t          sb[$];
  exp_t          monE;
  int nChecks = 0, nFails = 0;
  int rdCount = 0, cyc = 0, modelWc = 0, frameBits = 0;
  int readyMode = 0;
  int lastCyc = 0, firstCyc = 0, spanLen = 0;
  bit gapCheck = 0, haveLast = 0, spanCheck = 0, prevStall = 0;
  logic prevOut = 1'b0, prevFs = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: event occurred, expected none", name);
  endtask

  // A word goes into the FIFO model and its expected LSB-first frame into the scoreboard.
  task automatic applyStimulus(input logic [DW-1:0] word);
    exp_t e;
    fq.push_back(word);
    for (int i = 0; i < DW; i++) begin
      e.b     = word[i];
      e.first = (i == 0);
      e.last  = (i == FRAME_BITS - 1);
      sb.push_back(e);
    end
`ifdef PARITY_EN
    e.b     = ($countones(word) % 2) == 1;
    e.first = 1'b0;
    e.last  = 1'b1;
    sb.push_back(e);
`endif
  endtask

  task automatic waitIdle(input int budget, input bit needEmpty, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sif.o_busy == 1'b0 && (!needEmpty || (fq.size() == 0 && sif.i_fifo_empty)))
               && n < budget);
    checkOutput({name, "_idle_in_budget"}, n < budget, 1);
  endtask

  // Synchronous FIFO model: data appears after the edge that sampled cs & rd_en.
  initial begin
    sif.i_fifo_empty <= 1'b1;
    sif.i_fifo_data  <= '0;
    forever begin
      @(posedge clk);
      if (sif.o_fifo_cs && sif.o_fifo_rd_en) begin
        if (fq.size() == 0) failNow("read_of_empty_fifo");
        else sif.i_fifo_data <= fq.pop_front();
      end
      sif.i_fifo_empty <= (fq.size() == 0);
    end
  end

  always @(posedge clk) cyc++;

  initial begin
    sif.i_ser_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       sif.i_ser_ready = 1'b1;
        1:       sif.i_ser_ready = ~sif.i_ser_ready;
        default: sif.i_ser_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 0;
    end else begin
      if (sif.o_fifo_rd_en) rdCount++;
      checkOutput("cs_matches_rd_en", sif.o_fifo_cs, sif.o_fifo_rd_en);
      if (prevStall) begin
        checkOutput("stall_valid_held", sif.o_ser_valid, 1);
        checkOutput("stall_out_held", sif.o_ser_out, prevOut);
        checkOutput("stall_fs_held", sif.o_frame_start, prevFs);
      end
      if (sif.o_ser_valid && sif.i_ser_ready) begin
        if (sb.size() == 0) begin
          failNow("unexpected_serial_bit");
        end else begin
          monE = sb.pop_front();
          checkOutput("ser_out_bit", sif.o_ser_out, monE.b);
          checkOutput("frame_start_flag", sif.o_frame_start, monE.first);
          if (monE.first) begin
            if (gapCheck && haveLast) checkOutput("frame_gap_cycles", cyc - lastCyc - 1, 3);
            firstCyc  = cyc;
            frameBits = 1;
          end else begin
            frameBits++;
          end
          if (monE.last) begin
            haveLast = 1;
            lastCyc  = cyc;
            modelWc++;
            if (spanCheck) spanLen = cyc - firstCyc + 1;
          end
        end
      end
      prevStall = sif.o_ser_valid && !sif.i_ser_ready;
      prevOut   = sif.o_ser_out;
      prevFs    = sif.o_frame_start;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd0, lat, cnt;
    rst_n = 1'b0;
    sif.i_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with words waiting: nothing may move.
    for (int i = 0; i < 3; i++) applyStimulus($urandom);
    repeat (4) @(negedge clk);
    checkOutput("rst_fifo_cs", sif.o_fifo_cs, 0);
    checkOutput("rst_fifo_rd_en", sif.o_fifo_rd_en, 0);
    checkOutput("rst_ser_out", sif.o_ser_out, 0);
    checkOutput("rst_ser_valid", sif.o_ser_valid, 0);
    checkOutput("rst_frame_start", sif.o_frame_start, 0);
    checkOutput("rst_busy", sif.o_busy, 0);
    checkOutput("rst_word_count", sif.o_word_count, 0);
    checkOutput("rst_no_reads", rdCount, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!sif.o_fifo_rd_en && lat < 10);
    checkOutput("first_rd_latency", lat, 2);
    waitIdle(3000, 1, "t1");
    checkOutput("t1_word_count", sif.o_word_count, modelWc % (1 << WW));
    checkOutput("t1_rd_count", rdCount, 3);

    // Single known word.
    rd0 = rdCount;
    applyStimulus(32'h0000_00A5);
    waitIdle(1000, 1, "t2");
    checkOutput("t2_rd_pulses", rdCount - rd0, 1);
    checkOutput("t2_word_count", sif.o_word_count, modelWc % (1 << WW));
    checkOutput("t2_busy", sif.o_busy, 0);

    // Back-to-back words: three link cycles between frames.
    rd0 = rdCount;
    gapCheck = 1;
    haveLast = 0;
    applyStimulus(32'd1);
    applyStimulus(32'd20);
    applyStimulus(32'd120);
    waitIdle(2000, 1, "t3");
    gapCheck = 0;
    checkOutput("t3_rd_pulses", rdCount - rd0, 3);
    checkOutput("t3_word_count", sif.o_word_count, modelWc % (1 << WW));

    // Ready toggling every cycle stretches the frame to 2N-1 cycles.
    readyMode = 1;
    spanCheck = 1;
    spanLen = 0;
    applyStimulus(32'h8000_0001);
    waitIdle(2000, 1, "t4");
    spanCheck = 0;
    readyMode = 0;
    checkOutput("t4_frame_span", spanLen, 2 * FRAME_BITS - 1);

    // Random words with random backpressure.
    readyMode = 2;
    for (int i = 0; i < 6; i++) applyStimulus($urandom);
    waitIdle(5000, 1, "trand");
    readyMode = 0;
    checkOutput("trand_word_count", sif.o_word_count, modelWc % (1 << WW));

    // Asynchronous reset in the middle of a frame drops the partial word.
    frameBits = 0;
    applyStimulus(32'hFFFF_0000);
    applyStimulus($urandom);
    cnt = 0;
    while (frameBits < 10 && cnt < 1000) begin
      @(posedge clk);
      cnt++;
    end
    checkOutput("t5_reached_bit10", cnt < 1000, 1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_valid", sif.o_ser_valid, 0);
    checkOutput("t5_async_busy", sif.o_busy, 0);
    checkOutput("t5_async_word_count", sif.o_word_count, 0);
    checkOutput("t5_async_ser_out", sif.o_ser_out, 0);
    while (sb.size() > 0 && !sb[0].first) void'(sb.pop_front());
    modelWc  = 0;
    haveLast = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    waitIdle(1000, 1, "t5");
    checkOutput("t5_word_count", sif.o_word_count, modelWc % (1 << WW));

    // Parity-sensitive words.
    applyStimulus(32'h0000_0007);
    applyStimulus(32'h0000_0003);
    waitIdle(1000, 1, "t6");
    checkOutput("t6_word_count", sif.o_word_count, modelWc % (1 << WW));

    // Enable dropped mid-word: current word completes, the next stays queued.
    frameBits = 0;
    rd0 = rdCount;
    applyStimulus($urandom);
    applyStimulus($urandom);
    cnt = 0;
    while (frameBits < 5 && cnt < 1000) begin
      @(posedge clk);
      cnt++;
    end
    #1 sif.i_enable = 1'b0;
    waitIdle(1000, 0, "tdrop");
    repeat (10) @(negedge clk);
    checkOutput("tdrop_rd_pulses", rdCount - rd0, 1);
    checkOutput("tdrop_busy", sif.o_busy, 0);
    checkOutput("tdrop_pending_bits", sb.size(), FRAME_BITS);
    @(posedge clk);
    #1 sif.i_enable = 1'b1;
    waitIdle(1000, 1, "tdrop_resume");

    // Fill with enable low, then drain all eight.
    @(posedge clk);
    #1 sif.i_enable = 1'b0;
    rd0 = rdCount;
    for (int i = 0; i < 8; i++) applyStimulus($urandom);
    repeat (20) @(negedge clk);
    checkOutput("t7_no_reads_disabled", rdCount - rd0, 0);
    checkOutput("t7_busy_disabled", sif.o_busy, 0);
    @(posedge clk);
    #1 sif.i_enable = 1'b1;
    waitIdle(5000, 1, "t7");
    checkOutput("t7_rd_pulses", rdCount - rd0, 8);
    checkOutput("t7_word_count", sif.o_word_count, modelWc % (1 << WW));
    checkOutput("final_scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
